pipe_wbu: RTL and testbench
===========================

PIPE_WBU -- requirements
Module: pipe_wbu

Interface
REQ-001 Parameter: CNT_W, 64, width of the retired-instruction counter.
REQ-002 clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 exToWb_i  input  exToWb_t  payload from the execute stage: uop_info, alu_res, lsu_res.
REQ-005 ex_valid_i  input  1  execute-stage payload valid.
REQ-006 wb_ready_o  output  1  writeback can accept a payload this cycle.
REQ-007 rf_we_o  output  1  register-file write enable.
REQ-008 rf_waddr_o  output  5  register-file write index.
REQ-009 rf_wdata_o  output  ele_t  register-file write data.
REQ-010 wb_fwd_valid_o  output  1  forward valid to the execute stage.
REQ-011 wb_fwd_rd_o  output  5  forwarded destination index.
REQ-012 wb_fwd_data_o  output  ele_t  forwarded data; equals rf_wdata_o.
REQ-013 commit_valid_o  output  1  one instruction retires this cycle (difftest).
REQ-014 commit_pc_o  output  pc_t  pc of the retiring instruction.
REQ-015 commit_dnpc_o  output  pc_t  dnpc of the retiring instruction.
REQ-016 halt_o  output  1  sticky; set after an EBREAK retires.
REQ-017 retire_cnt_o  output  CNT_W  count of retired instructions.

Function
REQ-018 Input register: wb_valid_q/exToWb_q load when wb_ready_o is high; wb_valid_q takes ex_valid_i; payload loads only when ex_valid_i is high.
REQ-019 State machine {RUN, HALT}; reset state is RUN.
REQ-020 In RUN, wb_ready_o = 1 and a held instruction retires in the cycle after capture; no backpressure.
REQ-021 In HALT, wb_ready_o = 0; wb_valid_q = 0; no register write, commit or count.
REQ-022 RUN -> HALT when wb_valid_q is set and uop_info.fu_op == EBREAK; the EBREAK itself commits in that cycle.
REQ-023 HALT is left only by reset.
REQ-024 Write data: rf_wdata_o = lsu_res when fu_op == LOAD; otherwise rf_wdata_o = alu_res.
REQ-025 rf_we_o = wb_valid_q && uop_info.rd_wen && uop_info.rd != 0; rf_waddr_o = uop_info.rd.
REQ-026 Writes to x0 are suppressed; rd = 0 never asserts rf_we_o or wb_fwd_valid_o.
REQ-027 wb_fwd_valid_o = rf_we_o and wb_fwd_rd_o = rf_waddr_o; the forward path is combinational from the WB register.
REQ-028 commit_valid_o = wb_valid_q, asserted for exactly one cycle per instruction, including stores, branches and EBREAK.
REQ-029 commit_pc_o = uop_info.pc and commit_dnpc_o = uop_info.dnpc, as received.
REQ-030 retire_cnt_o increments by 1 on each commit_valid_o and wraps modulo 2^CNT_W.
REQ-031 Back-to-back: a new payload is captured in the same cycle the current one retires, giving 1 instruction/cycle throughput.
REQ-032 halt_o = (state == HALT).

Reset
REQ-033 Reset values: wb_valid_q = 0, state = RUN, retire_cnt_o = 0, halt_o = 0, and all enables (rf_we_o, wb_fwd_valid_o, commit_valid_o) = 0.
REQ-034 The payload register is not reset; no output may depend on it while wb_valid_q = 0.
REQ-035 Reset asserted mid-stream discards the held instruction without commit or register write.

Structure
REQ-036 The shared package (liang_pkg) holds exToWb_t, uop_info_t, ele_t, pc_t and the fu_op enumeration.
REQ-037 uop_info_t shall carry the rd, rd_wen and dnpc fields; the fu_op enumeration shall include the LOAD and EBREAK values.
REQ-038 The block has no sub-module; the FSM, counter and result mux are inline.

Verification
REQ-039 ALU op (rd=5, rd_wen=1, alu_res=0x1234), valid for 1 cycle -> next cycle rf_we_o=1, waddr=5, wdata=0x1234, fwd_valid=1, commit_valid=1, retire_cnt=1.
REQ-040 LOAD (rd=7, lsu_res=0xDEADBEEF, alu_res=0x80000010) -> wdata=0xDEADBEEF.
REQ-041 ALU op with rd=0 and rd_wen=1 -> rf_we_o=0 and fwd_valid=0, while commit_valid=1.
REQ-042 Ten back-to-back valid ops -> ten consecutive commit cycles, retire_cnt=10, wb_ready_o constantly 1.
REQ-043 EBREAK followed by an ALU op -> EBREAK commits and halt_o=1 the next cycle; wb_ready_o=0; the ALU op never commits; counter frozen.
REQ-044 Preload retire_cnt to 2^CNT_W-1 via force, then commit once -> counter wraps to 0. Separately, assert rst_i while wb_valid_q=1 -> no commit, all outputs at reset values.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared pipeline types for the liang core: element/pc types, the
// functional-unit opcode set, and the execute-to-writeback payload.
package liang_pkg;

  typedef logic [31:0] ele_t;
  typedef logic [31:0] pc_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4,
    EBREAK = 3'd5
  } fu_op_e;

  typedef struct packed {
    pc_t        pc;
    pc_t        dnpc;
    fu_op_e     fu_op;
    logic [4:0] rd;
    logic       rd_wen;
  } uop_info_t;

  typedef struct packed {
    uop_info_t uop_info;
    ele_t      alu_res;
    ele_t      lsu_res;
  } exToWb_t;

  // Register-file write qualifier: x0 is hardwired and never written.
  function automatic logic rd_write(input uop_info_t u);
    return u.rd_wen && (u.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_wbu.sv
// Writeback stage: holds one execute-stage payload, writes the register
// file, forwards the result, reports commits and halts after EBREAK.
module pipe_wbu
  import liang_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  exToWb_t          exToWb_i,
  input  logic             ex_valid_i,
  output logic             wb_ready_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output ele_t             rf_wdata_o,
  output logic             wb_fwd_valid_o,
  output logic [4:0]       wb_fwd_rd_o,
  output ele_t             wb_fwd_data_o,
  output logic             commit_valid_o,
  output pc_t              commit_pc_o,
  output pc_t              commit_dnpc_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q;
  logic             wb_valid_q;
  exToWb_t          exToWb_q;
  logic [CNT_W-1:0] retire_cnt_q;
  logic             retire_ebreak;

  assign wb_ready_o    = (state_q == RUN);
  assign retire_ebreak = wb_valid_q && (exToWb_q.uop_info.fu_op == EBREAK);

  // Control FSM, valid flag and retire counter.
  // A payload accepted in the same cycle EBREAK retires is dropped, so
  // nothing is ever held once the stage sits in HALT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      wb_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (wb_valid_q) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      case (state_q)
        RUN: begin
          if (retire_ebreak) begin
            state_q    <= HALT;
            wb_valid_q <= 1'b0;
          end else begin
            wb_valid_q <= ex_valid_i;
          end
        end
        HALT: wb_valid_q <= 1'b0;
        default: begin
          state_q    <= HALT;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload register, intentionally without reset.
  always_ff @(posedge clk_i) begin
    if (wb_ready_o && ex_valid_i) exToWb_q <= exToWb_i;
  end

  // Result mux and output gating; outputs never expose a stale payload.
  always_comb begin
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    commit_pc_o    = '0;
    commit_dnpc_o  = '0;
    if (wb_valid_q) begin
      rf_we_o       = rd_write(exToWb_q.uop_info);
      rf_waddr_o    = exToWb_q.uop_info.rd;
      rf_wdata_o    = (exToWb_q.uop_info.fu_op == LOAD) ? exToWb_q.lsu_res
                                                        : exToWb_q.alu_res;
      commit_pc_o   = exToWb_q.uop_info.pc;
      commit_dnpc_o = exToWb_q.uop_info.dnpc;
    end
    wb_fwd_valid_o = rf_we_o;
    wb_fwd_rd_o    = rf_waddr_o;
    wb_fwd_data_o  = rf_wdata_o;
    commit_valid_o = wb_valid_q;
    halt_o         = (state_q == HALT);
    retire_cnt_o   = retire_cnt_q;
  end

endmodule

// File: tb/tb_pipe_wbu.sv
// Self-checking bench for pipe_wbu: reference model of the writeback
// stage plus directed literal checks and randomized traffic.
module tb_pipe_wbu;
  import liang_pkg::*;

  localparam int unsigned CNT_W = 64;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  exToWb_t          exToWb_i;
  logic             ex_valid_i = 1'b0;
  logic             wb_ready_o;
  logic             rf_we_o;
  logic [4:0]       rf_waddr_o;
  ele_t             rf_wdata_o;
  logic             wb_fwd_valid_o;
  logic [4:0]       wb_fwd_rd_o;
  ele_t             wb_fwd_data_o;
  logic             commit_valid_o;
  pc_t              commit_pc_o;
  pc_t              commit_dnpc_o;
  logic             halt_o;
  logic [CNT_W-1:0] retire_cnt_o;

  int total = 0;
  int bad   = 0;

  pipe_wbu #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .exToWb_i       (exToWb_i),
    .ex_valid_i     (ex_valid_i),
    .wb_ready_o     (wb_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .wb_fwd_valid_o (wb_fwd_valid_o),
    .wb_fwd_rd_o    (wb_fwd_rd_o),
    .wb_fwd_data_o  (wb_fwd_data_o),
    .commit_valid_o (commit_valid_o),
    .commit_pc_o    (commit_pc_o),
    .commit_dnpc_o  (commit_dnpc_o),
    .halt_o         (halt_o),
    .retire_cnt_o   (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Holds at most one instruction; it retires one cycle after capture.
  logic             m_valid  = 1'b0;
  logic             m_halted = 1'b0;
  logic [CNT_W-1:0] m_cnt    = '0;
  exToWb_t          m_hold;
  logic             m_was_halted;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_cnt    = '0;
    end else begin
      m_was_halted = m_halted;
      if (m_valid) begin
        m_cnt = m_cnt + 1;
        if (m_hold.uop_info.fu_op == EBREAK) m_halted = 1'b1;
      end
      if (m_was_halted || m_halted) begin
        m_valid = 1'b0;
      end else begin
        m_valid = ex_valid_i;
        if (ex_valid_i) m_hold = exToWb_i;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit   cmp_en = 1'b0;
  logic e_we;
  ele_t e_data;

  always @(negedge clk_i) begin
    if (cmp_en) begin
      e_we   = m_valid && m_hold.uop_info.rd_wen && (m_hold.uop_info.rd != 5'd0);
      e_data = !m_valid ? 32'd0 :
               (m_hold.uop_info.fu_op == LOAD) ? m_hold.lsu_res : m_hold.alu_res;
      chk("m_ready",   64'(wb_ready_o),     64'(!m_halted));
      chk("m_halt",    64'(halt_o),         64'(m_halted));
      chk("m_commit",  64'(commit_valid_o), 64'(m_valid));
      chk("m_we",      64'(rf_we_o),        64'(e_we));
      chk("m_fwd_v",   64'(wb_fwd_valid_o), 64'(e_we));
      chk("m_cnt",     retire_cnt_o,        m_cnt);
      chk("m_waddr",   64'(rf_waddr_o),     m_valid ? 64'(m_hold.uop_info.rd) : 64'd0);
      chk("m_fwd_rd",  64'(wb_fwd_rd_o),    m_valid ? 64'(m_hold.uop_info.rd) : 64'd0);
      chk("m_wdata",   64'(rf_wdata_o),     64'(e_data));
      chk("m_fwd_d",   64'(wb_fwd_data_o),  64'(e_data));
      chk("m_pc",      64'(commit_pc_o),    m_valid ? 64'(m_hold.uop_info.pc) : 64'd0);
      chk("m_dnpc",    64'(commit_dnpc_o),  m_valid ? 64'(m_hold.uop_info.dnpc) : 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic exToWb_t mk(input fu_op_e op, input logic [4:0] rd, input logic wen,
                                 input ele_t alu, input ele_t lsu);
    exToWb_t p;
    p.uop_info.pc     = $urandom & 32'hFFFF_FFFC;
    p.uop_info.dnpc   = p.uop_info.pc + 32'd4;
    p.uop_info.fu_op  = op;
    p.uop_info.rd     = rd;
    p.uop_info.rd_wen = wen;
    p.alu_res         = alu;
    p.lsu_res         = lsu;
    return p;
  endfunction

  function automatic exToWb_t rnd_op();
    fu_op_e op;
    op = fu_op_e'($urandom_range(0, 4));
    return mk(op, 5'($urandom_range(0, 31)), 1'($urandom), $urandom, $urandom);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input exToWb_t p, input logic v);
    exToWb_i   = p;
    ex_valid_i = v;
  endtask

  int commits;
  logic [CNT_W-1:0] base;

  initial begin
    exToWb_i = rnd_op();
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    cmp_en = 1'b1;
    chk("rst_commit", 64'(commit_valid_o), 64'd0);
    chk("rst_we",     64'(rf_we_o),        64'd0);
    chk("rst_halt",   64'(halt_o),         64'd0);
    chk("rst_cnt",    retire_cnt_o,        64'd0);
    chk("rst_ready",  64'(wb_ready_o),     64'd1);

    // single ALU op
    drive(mk(ALU, 5'd5, 1'b1, 32'h1234, 32'h0), 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("alu_we",     64'(rf_we_o),        64'd1);
    chk("alu_waddr",  64'(rf_waddr_o),     64'd5);
    chk("alu_wdata",  64'(rf_wdata_o),     64'h1234);
    chk("alu_fwd_v",  64'(wb_fwd_valid_o), 64'd1);
    chk("alu_commit", 64'(commit_valid_o), 64'd1);
    tick();
    chk("alu_cnt",    retire_cnt_o,        64'd1);
    chk("alu_once",   64'(commit_valid_o), 64'd0);

    // LOAD selects lsu_res
    drive(mk(LOAD, 5'd7, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF), 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("ld_wdata",   64'(rf_wdata_o),     64'hDEAD_BEEF);
    chk("ld_waddr",   64'(rf_waddr_o),     64'd7);
    tick();

    // write to x0 is suppressed but still commits
    drive(mk(ALU, 5'd0, 1'b1, 32'h5555, 32'h0), 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("x0_we",      64'(rf_we_o),        64'd0);
    chk("x0_fwd_v",   64'(wb_fwd_valid_o), 64'd0);
    chk("x0_commit",  64'(commit_valid_o), 64'd1);
    tick();
    chk("x0_cnt",     retire_cnt_o,        64'd3);

    // random traffic, no EBREAK
    for (int i = 0; i < 300; i++) begin
      drive(rnd_op(), 1'($urandom_range(0, 3) != 0));
      tick();
    end
    ex_valid_i = 1'b0;
    tick();

    // ten back-to-back ops
    base    = m_cnt;
    commits = 0;
    for (int i = 0; i < 10; i++) begin
      drive(rnd_op(), 1'b1);
      tick();
      if (commit_valid_o === 1'b1) commits++;
      chk("b2b_ready", 64'(wb_ready_o), 64'd1);
    end
    ex_valid_i = 1'b0;
    chk("b2b_commits", 64'(commits), 64'd10);
    tick();
    chk("b2b_cnt", retire_cnt_o, base + 64'd10);

    // counter wrap
    force dut.retire_cnt_q = '1;
    m_cnt = '1;
    #1 release dut.retire_cnt_q;
    drive(mk(STORE, 5'd9, 1'b0, 32'h1, 32'h2), 1'b1);
    tick();
    ex_valid_i = 1'b0;
    tick();
    chk("wrap_cnt", retire_cnt_o, 64'd0);

    // reset while an instruction is held
    drive(mk(ALU, 5'd12, 1'b1, 32'hABCD, 32'h0), 1'b1);
    tick();
    ex_valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    chk("mrst_commit", 64'(commit_valid_o), 64'd0);
    chk("mrst_we",     64'(rf_we_o),        64'd0);
    chk("mrst_fwd_v",  64'(wb_fwd_valid_o), 64'd0);
    chk("mrst_cnt",    retire_cnt_o,        64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("mrst_after",  64'(commit_valid_o), 64'd0);

    // EBREAK halts; following op is dropped
    drive(mk(EBREAK, 5'd0, 1'b0, 32'h0, 32'h0), 1'b1);
    tick();
    drive(mk(ALU, 5'd3, 1'b1, 32'h77, 32'h0), 1'b1);
    chk("eb_commit", 64'(commit_valid_o), 64'd1);
    chk("eb_nohalt", 64'(halt_o),         64'd0);
    tick();
    ex_valid_i = 1'b0;
    chk("eb_halt",   64'(halt_o),         64'd1);
    chk("eb_ready",  64'(wb_ready_o),     64'd0);
    chk("eb_cnt",    retire_cnt_o,        64'd1);
    for (int i = 0; i < 5; i++) begin
      drive(rnd_op(), 1'b1);
      tick();
      chk("halt_commit", 64'(commit_valid_o), 64'd0);
      chk("halt_cnt",    retire_cnt_o,        64'd1);
    end
    ex_valid_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
